instr_loader: RTL and testbench
===============================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 32, meaning instruction-memory capacity in 32-bit words.
REQ-002 Parameter LEN_W, default 8, meaning width of the word-count input.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-low.
REQ-005 start_i  input  1  load request, sampled every cycle.
REQ-006 len_i  input  LEN_W  number of words to load, latched when start_i is accepted.
REQ-007 byte_i  input  8  stream byte.
REQ-008 byte_valid_i  input  1  byte_i is valid.
REQ-009 byte_ready_o  output  1  loader accepts byte_i this cycle.
REQ-010 im_we_o  output  1  instruction-memory write strobe.
REQ-011 im_addr_o  output  32  byte address of the word being written (word index x 4).
REQ-012 im_data_o  output  32  assembled instruction word.
REQ-013 cpu_rst_o  output  1  active-low reset to the CPU; low holds the CPU in reset.
REQ-014 busy_o, done_o, err_o  output  1 each  status: loading, load complete, load failed.

Function
REQ-015 The loader SHALL implement states IDLE, RECV, WRITE, CKSUM, DONE and ERR.
REQ-016 A byte SHALL transfer only in a cycle where byte_valid_i and byte_ready_o are both 1; byte_ready_o SHALL be 1 only in RECV and CKSUM.
REQ-017 In IDLE, DONE and ERR, start_i=1 SHALL latch len_i, clear the word index, byte counter and checksum, and enter RECV next cycle; start_i SHALL be ignored in RECV, WRITE and CKSUM.
REQ-018 len_i=0 or len_i>DEPTH_WORDS at start SHALL enter ERR instead of RECV.
REQ-019 In RECV, bytes SHALL assemble big-endian: first accepted byte goes to bits [31:24], fourth to [7:0].
REQ-020 The cycle after the fourth byte is accepted, the loader SHALL be in WRITE.
  - im_we_o=1 for exactly that one cycle.
  - im_addr_o = index x 4; im_data_o = assembled word.
REQ-021 From WRITE, if index = len-1 the loader SHALL go to CKSUM when LOADER_CHECKSUM_EN is defined, else to DONE; otherwise it SHALL increment index and return to RECV.
REQ-022 im_we_o SHALL be 0 in every state except WRITE; im_addr_o and im_data_o SHALL hold their last values outside WRITE.
REQ-023 cpu_rst_o SHALL be 1 only in DONE.
REQ-024 busy_o SHALL be 1 in RECV, WRITE and CKSUM; done_o SHALL be 1 only in DONE; err_o SHALL be 1 only in ERR.
REQ-025 Stalls (byte_valid_i=0) SHALL hold all state indefinitely with no timeout.
REQ-026 Re-start from DONE SHALL drive cpu_rst_o low from the first RECV cycle.

Reset
REQ-027 rst_i=0 at a rising edge SHALL force IDLE regardless of state, including mid-word and mid-WRITE.
REQ-028 Reset values SHALL be: byte_ready_o=0, im_we_o=0, im_addr_o=0, im_data_o=0, cpu_rst_o=0, busy_o=0, done_o=0, err_o=0, index=0, checksum=0.
REQ-029 A partially assembled word SHALL be discarded on reset and never written.

Configuration
REQ-030 With macro LOADER_CHECKSUM_EN defined, the loader SHALL keep an 8-bit running sum (mod 256) of all data bytes.
  - After the last WRITE it SHALL accept one extra byte in CKSUM.
  - It SHALL go to DONE if that byte equals the sum, else to ERR.
REQ-031 Without LOADER_CHECKSUM_EN, CKSUM SHALL be unreachable, no checksum byte SHALL be consumed, and the last WRITE SHALL go directly to DONE.

Verification
REQ-032 Reset, then start_i with len_i=2 and bytes 20 08 00 05 8C 01 00 04 sent back-to-back -> writes 0x20080005@0x0 and 0x8C010004@0x4, im_we_o one cycle each, then DONE with cpu_rst_o=1.
REQ-033 len_i=0 -> ERR next cycle, err_o=1, cpu_rst_o=0, im_we_o never asserted; len_i=33 with DEPTH_WORDS=32 -> same result.
REQ-034 byte_valid_i dropped for 5 cycles between bytes 2 and 3 -> assembled word unchanged, still a single write.
REQ-035 rst_i=0 after 2 bytes of word 1 -> IDLE, no write of word 1; a new load then starts at address 0x0.
REQ-036 LOADER_CHECKSUM_EN defined, len_i=1, bytes 01 02 03 04 then 0A -> DONE; same data with checksum byte 0B -> ERR, cpu_rst_o stays 0.
REQ-037 start_i pulsed during RECV -> ignored, load completes normally; start_i in DONE -> cpu_rst_o=0 next cycle and reload from 0x0.

Source files
------------

// File: rtl/instr_loader.sv
// Byte-stream instruction loader: assembles big-endian words into instruction memory, then releases the CPU.
// Optional: define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte before DONE.
module instr_loader #(
   parameter int DEPTH_WORDS = 32,
   parameter int LEN_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [7:0]       byte_i,
   input  logic             byte_valid_i,
   output logic             byte_ready_o,
   output logic             im_we_o,
   output logic [31:0]      im_addr_o,
   output logic [31:0]      im_data_o,
   output logic             cpu_rst_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [2:0]       dbg_state_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      CKSUM = 3'd3,
      DONE  = 3'd4,
      ERR   = 3'd5
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] index;
   logic [1:0]       byte_cnt;
   logic [23:0]      shift;
   logic [7:0]       sum;

   assign dbg_state_o = state;

   // Handshake: a byte moves on a rising edge only when byte_valid_i and byte_ready_o are both 1;
   // byte_ready_o is registered and is 1 exactly while the loader sits in RECV or CKSUM.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state        <= IDLE;
         len          <= '0;
         index        <= '0;
         byte_cnt     <= '0;
         shift        <= '0;
         sum          <= '0;
         byte_ready_o <= 1'b0;
         im_we_o      <= 1'b0;
         im_addr_o    <= '0;
         im_data_o    <= '0;
         cpu_rst_o    <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  len       <= len_i;
                  index     <= '0;
                  byte_cnt  <= '0;
                  sum       <= '0;
                  cpu_rst_o <= 1'b0;
                  done_o    <= 1'b0;
                  if (len_i == '0 || int'(len_i) > DEPTH_WORDS) begin
                     state        <= ERR;
                     err_o        <= 1'b1;
                     busy_o       <= 1'b0;
                     byte_ready_o <= 1'b0;
                  end else begin
                     state        <= RECV;
                     err_o        <= 1'b0;
                     busy_o       <= 1'b1;
                     byte_ready_o <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (byte_valid_i && byte_ready_o) begin
                  sum      <= sum + byte_i;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state        <= WRITE;
                     byte_ready_o <= 1'b0;
                     im_we_o      <= 1'b1;
                     im_data_o    <= {shift, byte_i};
                     im_addr_o    <= {{(30-LEN_W){1'b0}}, index, 2'b00};
                  end else begin
                     shift <= {shift[15:0], byte_i};
                  end
               end
            end
            WRITE: begin
               im_we_o <= 1'b0;
               if (index == len - LEN_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                  state        <= CKSUM;
                  byte_ready_o <= 1'b1;
`else
                  state     <= DONE;
                  busy_o    <= 1'b0;
                  done_o    <= 1'b1;
                  cpu_rst_o <= 1'b1;
`endif
               end else begin
                  index        <= index + LEN_W'(1);
                  state        <= RECV;
                  byte_ready_o <= 1'b1;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CKSUM: begin
               if (byte_valid_i && byte_ready_o) begin
                  byte_ready_o <= 1'b0;
                  busy_o       <= 1'b0;
                  if (byte_i == sum) begin
                     state     <= DONE;
                     done_o    <= 1'b1;
                     cpu_rst_o <= 1'b1;
                  end else begin
                     state <= ERR;
                     err_o <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state        <= IDLE;
               byte_ready_o <= 1'b0;
               im_we_o      <= 1'b0;
               cpu_rst_o    <= 1'b0;
               busy_o       <= 1'b0;
               done_o       <= 1'b0;
               err_o        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized/directed bench for instr_loader; expected writes come from grouping the byte stream into words.
module tb_instr_loader;

   localparam int DEPTH = 32;
   localparam int LW    = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          start_i = 1'b0;
   logic [LW-1:0] len_i = '0;
   logic [7:0]    byte_i = '0;
   logic          byte_valid_i = 1'b0;
   logic          byte_ready_o, im_we_o, cpu_rst_o, busy_o, done_o, err_o;
   logic [31:0]   im_addr_o, im_data_o;
   logic [2:0]    dbg_state_o;

   int total = 0;
   int bad   = 0;

   logic [7:0]  stim[$];
   logic [63:0] exp_q[$];
   logic [63:0] obs_q[$];
   logic        prev_we = 1'b0;

   instr_loader #(.DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
      .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
      .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_data_o(im_data_o),
      .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .dbg_state_o(dbg_state_o)
   );

   // clock / watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // write monitor
   always @(negedge clk_i) begin
      if (im_we_o === 1'b1) begin
         obs_q.push_back({im_addr_o, im_data_o});
         check("we_single_cycle", {63'd0, prev_we}, 64'd0);
      end
      prev_we <= im_we_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      start_i = 1'b0;
      byte_valid_i = 1'b0;
      repeat (2) tick();
      rst_i = 1'b1;
   endtask

   task automatic check_status(input string tag, input bit b, input bit d, input bit e, input bit c);
      check({tag, "_busy"}, {63'd0, busy_o}, {63'd0, b});
      check({tag, "_done"}, {63'd0, done_o}, {63'd0, d});
      check({tag, "_err"}, {63'd0, err_o}, {63'd0, e});
      check({tag, "_cpu_rst"}, {63'd0, cpu_rst_o}, {63'd0, c});
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      byte_i = b;
      byte_valid_i = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (byte_ready_o === 1'b1) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      byte_valid_i = 1'b0;
      if (!ok) check("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic start_load(input int len);
      len_i = LW'(len);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   // Load stim[0 .. 4*len-1]; bad_ck only matters when the checksum byte is in use.
   task automatic run_load(input int len, input int stall_at, input int pulse_at, input bit bad_ck);
      int ck;
      logic [31:0] w;
      logic [7:0] ckb;
      exp_q.delete();
      obs_q.delete();
      ck = 0;
      for (int i = 0; i < len; i++) begin
         w = {stim[4*i], stim[4*i+1], stim[4*i+2], stim[4*i+3]};
         exp_q.push_back({32'(i * 4), w});
      end
      for (int i = 0; i < 4 * len; i++) ck = (ck + int'(stim[i])) % 256;

      start_load(len);
      check_status("start", 1'b1, 1'b0, 1'b0, 1'b0);
      check("start_ready", {63'd0, byte_ready_o}, 64'd1);

      for (int i = 0; i < 4 * len; i++) begin
         if (i == stall_at) begin
            repeat (5) tick();
            check("stall_ready", {63'd0, byte_ready_o}, 64'd1);
            check("stall_no_we", {63'd0, im_we_o}, 64'd0);
         end
         send_byte(stim[i]);
         if (i % 4 == 3) begin
            check("write_we", {63'd0, im_we_o}, 64'd1);
            check("write_addr", {32'd0, im_addr_o}, {32'd0, exp_q[i/4][63:32]});
            check("write_data", {32'd0, im_data_o}, {32'd0, exp_q[i/4][31:0]});
         end
         if (i == pulse_at) begin
            len_i = '0;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            len_i = LW'(len);
         end
      end

`ifdef LOADER_CHECKSUM_EN
      tick();
      check("cksum_ready", {63'd0, byte_ready_o}, 64'd1);
      check_status("cksum", 1'b1, 1'b0, 1'b0, 1'b0);
      ckb = bad_ck ? (8'(ck) ^ 8'($urandom_range(1, 255))) : 8'(ck);
      send_byte(ckb);
      if (bad_ck) check_status("ck_bad", 1'b0, 1'b0, 1'b1, 1'b0);
      else        check_status("ck_good", 1'b0, 1'b1, 1'b0, 1'b1);
      check("ck_end_ready", {63'd0, byte_ready_o}, 64'd0);
`else
      ckb = 8'(ck);
      if (bad_ck) ckb = ~ckb;
      byte_i = ckb;
      byte_valid_i = 1'b1;
      tick();
      check_status("done", 1'b0, 1'b1, 1'b0, 1'b1);
      check("done_ready", {63'd0, byte_ready_o}, 64'd0);
      tick();
      check_status("done_hold", 1'b0, 1'b1, 1'b0, 1'b1);
      byte_valid_i = 1'b0;
`endif
      check("hold_we", {63'd0, im_we_o}, 64'd0);
      check("hold_addr", {32'd0, im_addr_o}, {32'd0, exp_q[len-1][63:32]});
      check("hold_data", {32'd0, im_data_o}, {32'd0, exp_q[len-1][31:0]});
      check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         check("write_entry", obs_q[i], exp_q[i]);
   endtask

   task automatic fill_random(input int len);
      stim.delete();
      for (int i = 0; i < 4 * len; i++) stim.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic bad_len(input int len);
      obs_q.delete();
      start_load(len);
      check_status("badlen", 1'b0, 1'b0, 1'b1, 1'b0);
      check("badlen_ready", {63'd0, byte_ready_o}, 64'd0);
      repeat (3) tick();
      check_status("badlen_hold", 1'b0, 1'b0, 1'b1, 1'b0);
      check("badlen_no_write", 64'(obs_q.size()), 64'd0);
   endtask

   initial begin
      int len;
      do_reset();
      check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset_ready", {63'd0, byte_ready_o}, 64'd0);
      check("reset_we", {63'd0, im_we_o}, 64'd0);
      check("reset_addr", {32'd0, im_addr_o}, 64'd0);
      check("reset_data", {32'd0, im_data_o}, 64'd0);

      // directed two-word program, back-to-back bytes
      stim = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h01, 8'h00, 8'h04};
      run_load(2, -1, -1, 1'b0);
      check("directed_w0", exp_q[0], {32'h0, 32'h20080005});
      check("directed_w1", exp_q[1], {32'h4, 32'h8C010004});

      // restart from DONE, with stall and a stray start pulse mid-load
      fill_random(3);
      run_load(3, 2, 5, 1'b0);

      bad_len(0);
      bad_len(DEPTH + 1);

      // reset mid-word discards the partial word
      fill_random(2);
      obs_q.delete();
      start_load(2);
      send_byte(stim[0]);
      send_byte(stim[1]);
      do_reset();
      check_status("midword_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      check("midword_rst_ready", {63'd0, byte_ready_o}, 64'd0);
      check("midword_no_write", 64'(obs_q.size()), 64'd0);
      fill_random(1);
      run_load(1, -1, -1, 1'b0);

      // reset during WRITE
      fill_random(1);
      start_load(1);
      for (int i = 0; i < 4; i++) send_byte(stim[i]);
      check("midwrite_we", {63'd0, im_we_o}, 64'd1);
      do_reset();
      check("midwrite_rst_we", {63'd0, im_we_o}, 64'd0);
      check("midwrite_rst_addr", {32'd0, im_addr_o}, 64'd0);
      check("midwrite_rst_data", {32'd0, im_data_o}, 64'd0);
      check_status("midwrite_rst", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      stim = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_load(1, -1, -1, 1'b0);
      run_load(1, -1, -1, 1'b1);
`endif

      // full-depth load
      fill_random(DEPTH);
      run_load(DEPTH, $urandom_range(1, 3), -1, 1'b0);

      for (int it = 0; it < 6; it++) begin
         len = $urandom_range(1, 6);
         fill_random(len);
         run_load(len, (it % 2 == 0) ? $urandom_range(1, 3) : -1,
                  (it % 3 == 0) ? $urandom_range(0, 4 * len - 2) : -1,
                  1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
